// File: rtl/mem_stage_ctrl_pkg.sv
// Purpose : shared state encoding and memory-op codes for the MEM-stage access controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_ctrl_pkg;

    // 3-bit state encoding of the access FSM.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // mem_writeEn codes from EX/MEM; 2'b0x means no access.
    localparam logic [1:0] MEMOP_LOAD  = 2'b10;
    localparam logic [1:0] MEMOP_STORE = 2'b11;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Purpose : request/response bus between the MEM-stage controller and a multi-cycle data memory.
// Latency : n/a (wires only).
// Backpressure: mem_busy holds the request strobe; mem_done completes it.
// Ports   : mem_en/mem_wr/mem_addr/mem_wdata (controller -> memory),
//           mem_busy/mem_done/mem_rdata (memory -> controller).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_en;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_busy, mem_done, mem_rdata
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_busy, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// Purpose : WAIT-state timeout counter with synchronous clear, enable and terminal count.
// Latency : tc is combinational from the count; count updates one cycle after en.
// Backpressure: none; holds at terminal count until cleared.
// Ports   : clk, rst (async active-low), clr, en in; tc out (count == TIMEOUT-1).
module mem_stage_ctrl_timeout_cnt #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt_q;

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose : MEM-stage controller turning the EX/MEM access into one request to a multi-cycle memory.
// Latency : load completing k cycles after the memory accepts it stalls the pipe k+2 cycles.
// Backpressure: re-presents the request while mem_busy; stalls upstream until mem_done or timeout.
// Ports   : clk, rst (async active-low); mem_writeEn/addr/wdata/halt from EX/MEM;
//           mem (memory bus, master side); stall, rdata, rdata_valid, err, halted to the pipeline.
// TIMEOUT must be >= 2 and 2**CNT_W must exceed TIMEOUT.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_writeEn,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              halt,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              halted
);
    state_t            state_q, state_d;
    logic              wr_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic access, aligned;
    logic latch_req, cap_rdata, err_d;
    logic in_wait, tc;

    assign in_wait = (state_q == ST_WAIT);

    // Counter is held at zero outside WAIT, so each WAIT visit starts from 0.
    mem_stage_ctrl_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_wait),
        .en  (in_wait),
        .tc  (tc)
    );

    always_comb begin
        access    = (mem_writeEn == MEMOP_LOAD) || (mem_writeEn == MEMOP_STORE);
        aligned   = ~addr[0];
        state_d   = state_q;
        latch_req = 1'b0;
        cap_rdata = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An access outranks halt so a halting store still completes first.
                if (access) begin
                    if (aligned) begin
                        latch_req = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_REQ: begin
                if (!mem.mem_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // mem_done wins over a timeout landing in the same cycle.
                if (mem.mem_done) begin
                    cap_rdata = ~wr_q;
                    state_d   = ST_DONE;
                end else if (tc) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                // Access inputs still show the retiring instruction here; only halt matters.
                state_d = halt ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (latch_req) begin
                wr_q    <= (mem_writeEn == MEMOP_STORE);
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (cap_rdata) begin
                rdata_q <= mem.mem_rdata;
            end
        end
    end

    assign mem.mem_en    = (state_q == ST_REQ);
    assign mem.mem_wr    = (state_q == ST_REQ) & wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Gated by rst so stall reads 0 while reset is held even with an access on the inputs.
    assign stall = rst & (((state_q == ST_IDLE) & access & aligned)
                          | (state_q == ST_REQ) | in_wait);

    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == ST_DONE) & ~wr_q;
    assign err         = err_q;
    assign halted      = (state_q == ST_HALTED);
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose : self-checking bench for mem_stage_ctrl: directed vector table, corner sequences, random transactions.
// Latency : n/a.
// Backpressure: the bench models the memory (busy/done timing) and a pipeline that holds its instruction while stalled.
module tb_mem_stage_ctrl;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int BUDGET  = 120;
    localparam int N_VEC   = 9;
    localparam int N_RAND  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_writeEn;
    logic [15:0] addr, wdata;
    logic        halt;
    logic        stall, rdata_valid, err, halted;
    logic [15:0] rdata;

    mem_stage_ctrl_if #(.DATA_W(DATA_W)) mif ();

    mem_stage_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_writeEn (mem_writeEn),
        .addr        (addr),
        .wdata       (wdata),
        .halt        (halt),
        .mem         (mif),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] ref_rdata;

    typedef struct {
        int n_stall;
        int n_en;
        int n_err;
        int n_rv;
        int dly;     // cycles from last mem_en to DONE (success) or to err (timeout); -1 if none
    } exp_t;

    typedef struct {
        int n_stall;
        int n_en;
        int n_err;
        int n_rv;
        int last_en;
        int err_at;
        int ret_at;
        int halt_at;
        int bad_req;
        bit timed_out;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] wd;
        int          busy_n;
        int          done_n;   // mem_done on the done_n-th cycle after acceptance; 0 = never
        logic [15:0] rd;
        exp_t        e;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic bubble();
        mem_writeEn   = 2'b00;
        addr          = 16'h0;
        wdata         = 16'h0;
        halt          = 1'b0;
        mif.mem_busy  = 1'b0;
        mif.mem_done  = 1'b0;
        mif.mem_rdata = 16'h0;
    endtask

    // Transaction-level reference: stall/request counts and latency from the access rules.
    function automatic exp_t predict(input logic [1:0] op, input logic [15:0] a,
                                     input int busy_n, input int done_n);
        exp_t e;
        e.n_stall = 0; e.n_en = 0; e.n_err = 0; e.n_rv = 0; e.dly = -1;
        if (!op[1]) return e;
        if (a[0]) begin
            e.n_err = 1;
            return e;
        end
        e.n_en = busy_n + 1;
        if (done_n >= 1 && done_n <= TIMEOUT) begin
            e.n_stall = 1 + e.n_en + done_n;
            e.n_rv    = op[0] ? 0 : 1;
            e.dly     = done_n + 1;
        end else begin
            e.n_stall = 1 + e.n_en + TIMEOUT;
            e.n_err   = 1;
            e.dly     = TIMEOUT + 1;
        end
        return e;
    endfunction

    // Presents one instruction, holds it while stalled, drops it on retire or err,
    // plays the memory side, then idles a few cycles; returns what was observed.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd,
                           input int busy_n, input int done_n, input logic [15:0] rd,
                           input logic hlt, output res_t r);
        bit holding   = 1'b1;
        int en_busy   = 0;
        int since_acc = 0;
        int post      = 0;
        r.n_stall = 0; r.n_en = 0; r.n_err = 0; r.n_rv = 0; r.bad_req = 0;
        r.last_en = -1; r.err_at = -1; r.ret_at = -1; r.halt_at = -1;
        r.timed_out = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (err === 1'b1) holding = 1'b0;
            mem_writeEn   = holding ? op : 2'b00;
            addr          = a;
            wdata         = wd;
            halt          = holding & hlt;
            mif.mem_busy  = (since_acc == 0) && (en_busy < busy_n);
            mif.mem_done  = (done_n > 0) && (since_acc == done_n);
            mif.mem_rdata = mif.mem_done ? rd : ~rd;
            #1;
            if (mif.mem_en === 1'b1) begin
                r.n_en++;
                r.last_en = c;
                if (mif.mem_addr !== a || mif.mem_wdata !== wd || mif.mem_wr !== op[0]) r.bad_req++;
            end
            if (stall === 1'b1) r.n_stall++;
            if (err === 1'b1) begin r.n_err++; r.err_at = c; end
            if (rdata_valid === 1'b1) r.n_rv++;
            if (halted === 1'b1 && r.halt_at < 0) r.halt_at = c;
            if (holding && stall !== 1'b1) begin holding = 1'b0; r.ret_at = c; end
            if (since_acc > 0) since_acc++;
            else if (mif.mem_en === 1'b1) begin
                if (mif.mem_busy) en_busy++;
                else since_acc = 1;
            end
            if (!holding) post++;
            if (post > 4) begin r.timed_out = 1'b0; break; end
        end
        mif.mem_done = 1'b0;
        mif.mem_busy = 1'b0;
    endtask

    task automatic compare_txn(input string tag, input res_t r, input exp_t e, input logic [15:0] exp_rd);
        check($sformatf("%s.budget", tag), 32'(r.timed_out), 32'd0);
        check($sformatf("%s.stall_cycles", tag), r.n_stall, e.n_stall);
        check($sformatf("%s.mem_en_cycles", tag), r.n_en, e.n_en);
        check($sformatf("%s.err_pulses", tag), r.n_err, e.n_err);
        check($sformatf("%s.rdata_valid_pulses", tag), r.n_rv, e.n_rv);
        check($sformatf("%s.req_unstable", tag), r.bad_req, 0);
        check($sformatf("%s.rdata", tag), rdata, exp_rd);
        if (e.dly >= 0)
            check($sformatf("%s.latency", tag),
                  (e.n_err > 0 ? r.err_at : r.ret_at) - r.last_en, e.dly);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.mem_en", tag), mif.mem_en, 0);
        check($sformatf("%s.mem_wr", tag), mif.mem_wr, 0);
        check($sformatf("%s.mem_addr", tag), mif.mem_addr, 0);
        check($sformatf("%s.mem_wdata", tag), mif.mem_wdata, 0);
        check($sformatf("%s.stall", tag), stall, 0);
        check($sformatf("%s.rdata", tag), rdata, 0);
        check($sformatf("%s.rdata_valid", tag), rdata_valid, 0);
        check($sformatf("%s.err", tag), err, 0);
        check($sformatf("%s.halted", tag), halted, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res_t r;
        exp_t e;
        int   not_halted;
        int   en_seen;
        int   stall_seen;

        vecs[0] = '{2'b10, 16'h0040, 16'h0000, 0, 3,  16'hBEEF, '{5, 1, 0, 1, 4},   16'hBEEF};
        vecs[1] = '{2'b11, 16'h0042, 16'h1234, 2, 1,  16'h7777, '{5, 3, 0, 0, 2},   16'hBEEF};
        vecs[2] = '{2'b10, 16'h0041, 16'h0000, 0, 2,  16'h1111, '{0, 0, 1, 0, -1},  16'hBEEF};
        vecs[3] = '{2'b10, 16'h0080, 16'h0000, 0, 0,  16'hDEAD, '{18, 1, 1, 0, 17}, 16'hBEEF};
        vecs[4] = '{2'b10, 16'h0044, 16'h0000, 0, 16, 16'h5A5A, '{18, 1, 0, 1, 17}, 16'h5A5A};
        vecs[5] = '{2'b01, 16'h0046, 16'h9999, 0, 1,  16'h2222, '{0, 0, 0, 0, -1},  16'h5A5A};
        vecs[6] = '{2'b11, 16'h0043, 16'hABCD, 0, 1,  16'h3333, '{0, 0, 1, 0, -1},  16'h5A5A};
        vecs[7] = '{2'b10, 16'h0046, 16'h0000, 1, 1,  16'hC3C3, '{4, 2, 0, 1, 2},   16'hC3C3};
        vecs[8] = '{2'b10, 16'h0048, 16'h0000, 0, 17, 16'h7E7E, '{18, 1, 1, 0, 17}, 16'hC3C3};

        // Reset with an aligned load and mem_done on the inputs: every output must read 0.
        rst           = 1'b0;
        mem_writeEn   = 2'b10;
        addr          = 16'h0040;
        wdata         = 16'hFFFF;
        halt          = 1'b1;
        mif.mem_busy  = 1'b0;
        mif.mem_done  = 1'b1;
        mif.mem_rdata = 16'hFFFF;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        bubble();
        rst = 1'b1;
        ref_rdata = 16'h0;

        for (int i = 0; i < N_VEC; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].busy_n, vecs[i].done_n,
                    vecs[i].rd, 1'b0, r);
            compare_txn($sformatf("vec%0d", i), r, vecs[i].e, vecs[i].exp_rdata);
        end
        ref_rdata = 16'hC3C3;

        // Reset pulled mid-WAIT while the load is still on the inputs.
        @(negedge clk);
        mem_writeEn = 2'b10; addr = 16'h004C; wdata = 16'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_wait.stall_before", stall, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        bubble();
        rst = 1'b1;
        ref_rdata = 16'h0;
        run_txn(2'b10, 16'h004A, 16'h0, 1, 2, 16'h6B6B, 1'b0, r);
        e = predict(2'b10, 16'h004A, 1, 2);
        ref_rdata = 16'h6B6B;
        compare_txn("post_rst_load", r, e, ref_rdata);

        // Random transactions against the transaction-level model.
        for (int i = 0; i < N_RAND; i++) begin
            logic [1:0]  op;
            logic [15:0] a, wd, rd;
            int          busy_n, done_n;
            op = 2'($urandom_range(3, 0));
            a  = 16'($urandom);
            if ($urandom_range(3, 0) != 0) a[0] = 1'b0;
            wd     = 16'($urandom);
            rd     = 16'($urandom);
            busy_n = int'($urandom_range(3, 0));
            done_n = int'($urandom_range(TIMEOUT + 2, 0));
            e = predict(op, a, busy_n, done_n);
            if (e.n_rv == 1) ref_rdata = rd;
            run_txn(op, a, wd, busy_n, done_n, rd, 1'b0, r);
            compare_txn($sformatf("rand%0d", i), r, e, ref_rdata);
        end

        // Store issued with halt: completes, then the stage parks.
        run_txn(2'b11, 16'h0050, 16'h4321, 0, 2, 16'h0, 1'b1, r);
        e = predict(2'b11, 16'h0050, 0, 2);
        compare_txn("halt_store", r, e, ref_rdata);
        check("halt_store.halted_after_done", r.halt_at - r.ret_at, 1);

        not_halted = 0; en_seen = 0; stall_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_writeEn   = (c % 2 == 0) ? 2'b10 : 2'b11;
            addr          = 16'h0060;
            mif.mem_done  = 1'b1;
            #1;
            if (halted !== 1'b1) not_halted++;
            if (mif.mem_en !== 1'b0) en_seen++;
            if (stall !== 1'b0) stall_seen++;
        end
        check("halted.sticky", not_halted, 0);
        check("halted.no_mem_en", en_seen, 0);
        check("halted.no_stall", stall_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
